// File: rtl/echo_processor.sv
// Echo stage between the ADC receiver and the DAC/PWM drivers: y[n] = x[n] + (y[n-D] >>> G),
// with a circular on-chip delay line holding past outputs in signed (offset-removed) form.
module echo_processor #(
    parameter int ADDR_W     = 13,
    parameter int ADC_OFFSET = 385
) (
    input  logic              sysclk,
    input  logic              rst_n,
    input  logic [9:0]        data_in,
    input  logic              data_valid,
    input  logic [ADDR_W-1:0] delay_sel,
    input  logic [1:0]        gain_shift,
    output logic [9:0]        data_out,
    output logic              out_valid,
    output logic              busy
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic signed [11:0] L_MIN = 12'(-ADC_OFFSET);
    localparam logic signed [11:0] L_MAX = 12'(1023 - ADC_OFFSET);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_CALC,
        S_WRITE
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic        [10:0]       r_mem [DEPTH];
    logic signed [10:0]       r_rd_data;
    logic        [ADDR_W-1:0] r_rd_addr;
    logic        [ADDR_W-1:0] r_wr_ptr;
    logic        [ADDR_W:0]   r_fill_cnt;
    logic signed [10:0]       r_x;
    logic        [ADDR_W-1:0] r_d;
    logic        [1:0]        r_g;
    logic        [10:0]       r_sum;
    logic        [9:0]        r_data_out;
    logic                     r_out_valid;

    logic                     w_echo_en;
    logic signed [10:0]       w_fb;
    logic signed [11:0]       w_sum;
    logic        [10:0]       w_clamped;

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (data_valid) w_state_next = S_READ;
            S_READ:  w_state_next = S_WAIT;
            S_WAIT:  w_state_next = S_CALC;
            S_CALC:  w_state_next = S_WRITE;
            S_WRITE: w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Feedback only once the delay line holds D genuine outputs since reset.
    assign w_echo_en = (r_d != '0) && (r_g != 2'd0) && (r_fill_cnt >= {1'b0, r_d});
    assign w_fb      = w_echo_en ? (r_rd_data >>> r_g) : 11'sd0;
    assign w_sum     = {r_x[10], r_x} + {w_fb[10], w_fb};

    always_comb begin
        w_clamped = w_sum[10:0];
        if (w_sum < L_MIN) begin
            w_clamped = L_MIN[10:0];
        end else if (w_sum > L_MAX) begin
            w_clamped = L_MAX[10:0];
        end
    end

    // Per-sample datapath registers need no reset; they are always loaded before use.
    always_ff @(posedge sysclk) begin
        case (r_state)
            S_IDLE: begin
                if (data_valid) begin
                    r_x <= {1'b0, data_in} - 11'(ADC_OFFSET);
                    r_d <= delay_sel;
                    r_g <= gain_shift;
                end
            end
            S_READ:  r_rd_addr <= r_wr_ptr - r_d;
            S_CALC:  r_sum <= w_clamped;
            default: ;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!rst_n) begin
            r_wr_ptr    <= '0;
            r_fill_cnt  <= '0;
            r_data_out  <= 10'(ADC_OFFSET);
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            if (r_state == S_WRITE) begin
                r_data_out  <= 10'(r_sum + 11'(ADC_OFFSET));
                r_out_valid <= 1'b1;
                r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
                if (r_fill_cnt != (ADDR_W + 1)'(DEPTH)) begin
                    r_fill_cnt <= r_fill_cnt + (ADDR_W + 1)'(1);
                end
            end
        end
    end

    // Block RAM: registered read, write suppressed while reset is asserted.
    always_ff @(posedge sysclk) begin
        if (rst_n && (r_state == S_WRITE)) begin
            r_mem[r_wr_ptr] <= r_sum;
        end
        r_rd_data <= r_mem[r_rd_addr];
    end

    assign data_out  = r_data_out;
    assign out_valid = r_out_valid;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_echo_processor.sv
// Directed bench for echo_processor: a full-depth instance and a 16-deep instance for
// pointer wrap, checked against a history-based echo model through an expected-value queue.
module tb_echo_processor;

    logic        sysclk = 1'b0;
    always #10 sysclk = ~sysclk;

    logic        a_rst_n = 1'b0;
    logic [9:0]  a_data_in = 10'd0;
    logic        a_data_valid = 1'b0;
    logic [12:0] a_delay = 13'd0;
    logic [1:0]  a_gain = 2'd0;
    logic [9:0]  a_data_out;
    logic        a_out_valid;
    logic        a_busy;

    logic        b_rst_n = 1'b0;
    logic [9:0]  b_data_in = 10'd0;
    logic        b_data_valid = 1'b0;
    logic [3:0]  b_delay = 4'd0;
    logic [1:0]  b_gain = 2'd0;
    logic [9:0]  b_data_out;
    logic        b_out_valid;
    logic        b_busy;

    echo_processor #(.ADDR_W(13), .ADC_OFFSET(385)) u_dut_a (
        .sysclk(sysclk), .rst_n(a_rst_n), .data_in(a_data_in), .data_valid(a_data_valid),
        .delay_sel(a_delay), .gain_shift(a_gain), .data_out(a_data_out),
        .out_valid(a_out_valid), .busy(a_busy)
    );

    echo_processor #(.ADDR_W(4), .ADC_OFFSET(385)) u_dut_b (
        .sysclk(sysclk), .rst_n(b_rst_n), .data_in(b_data_in), .data_valid(b_data_valid),
        .delay_sel(b_delay), .gain_shift(b_gain), .data_out(b_data_out),
        .out_valid(b_out_valid), .busy(b_busy)
    );

    bit   sel = 1'b0;
    logic [9:0] mon_data_out;
    logic       mon_out_valid;
    logic       mon_busy;
    assign mon_data_out  = sel ? b_data_out  : a_data_out;
    assign mon_out_valid = sel ? b_out_valid : a_out_valid;
    assign mon_busy      = sel ? b_busy      : a_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_q[$];
    int hist[$];

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    // Reference: y[n] = clamp(x[n] + y[n-D] >>> G), no feedback before D outputs exist.
    function automatic int model_step(input int din, input int d, input int g);
        int x, fb, s, n;
        x  = din - 385;
        fb = 0;
        n  = hist.size();
        if (d != 0 && g != 0 && n >= d) fb = hist[n - d] >>> g;
        s = x + fb;
        if (s < -385) s = -385;
        if (s > 638)  s = 638;
        hist.push_back(s);
        return s + 385;
    endfunction

    task automatic do_reset(input bit which);
        @(negedge sysclk);
        sel = which;
        if (which) b_rst_n = 1'b0; else a_rst_n = 1'b0;
        repeat (3) @(negedge sysclk);
        if (which) b_rst_n = 1'b1; else a_rst_n = 1'b1;
        hist.delete();
        exp_q.delete();
        chk("rst_data_out", int'(mon_data_out), 385);
        chk("rst_out_valid", int'(mon_out_valid), 0);
        chk("rst_busy", int'(mon_busy), 0);
        $display("reset dut=%0d data_out=%0d", which, mon_data_out);
    endtask

    task automatic send(input bit which, input int din, input int d, input int g);
        int lat;
        int exp_v;
        @(negedge sysclk);
        sel = which;
        if (which) begin
            b_data_in = 10'(din); b_delay = 4'(d); b_gain = 2'(g); b_data_valid = 1'b1;
        end else begin
            a_data_in = 10'(din); a_delay = 13'(d); a_gain = 2'(g); a_data_valid = 1'b1;
        end
        exp_q.push_back(model_step(din, d, g));
        @(negedge sysclk);
        // Disturb settings mid-sample: they must have been captured at the strobe.
        if (which) begin
            b_data_valid = 1'b0; b_delay = ~b_delay; b_gain = ~b_gain; b_data_in = ~b_data_in;
        end else begin
            a_data_valid = 1'b0; a_delay = ~a_delay; a_gain = ~a_gain; a_data_in = ~a_data_in;
        end
        chk("busy_high", int'(mon_busy), 1);
        lat = 0;
        while (!mon_out_valid && lat < 10) begin
            @(negedge sysclk);
            lat++;
        end
        chk("latency", lat, 4);
        exp_v = exp_q.pop_front();
        chk("data_out", int'(mon_data_out), exp_v);
        chk("busy_idle", int'(mon_busy), 0);
        $display("dut=%0d in=%0d D=%0d G=%0d out=%0d exp=%0d lat=%0d",
                 which, din, d, g, mon_data_out, exp_v, lat);
        @(negedge sysclk);
        chk("pulse_width", int'(mon_out_valid), 0);
    endtask

    initial begin
        int pulses;

        do_reset(1'b0);
        send(1'b0, 500, 0, 1);
        for (int i = 0; i < 10; i++) send(1'b0, 700, 100, 0);

        do_reset(1'b0);
        send(1'b0, 641, 4, 1);
        for (int i = 0; i < 8; i++) send(1'b0, 385, 4, 1);

        do_reset(1'b0);
        for (int i = 0; i < 10; i++) send(1'b0, 1023, 1, 1);
        for (int i = 0; i < 10; i++) send(1'b0, 0, 1, 1);

        // Fill RAM far beyond the startup-guard read window with nonzero samples.
        for (int i = 0; i < 300; i++) send(1'b0, 1023, 0, 0);
        do_reset(1'b0);
        for (int i = 0; i < 100; i++) send(1'b0, 385, 8000, 1);

        do_reset(1'b1);
        send(1'b1, 1023, 3, 1);
        for (int i = 1; i < 40; i++) send(1'b1, (i * 137 + 90) % 1024, 3, 1);

        // Abort a sample in CALC with reset.
        @(negedge sysclk);
        b_data_in = 10'd900; b_delay = 4'd3; b_gain = 2'd1; b_data_valid = 1'b1;
        @(negedge sysclk);
        b_data_valid = 1'b0;
        @(negedge sysclk);
        @(negedge sysclk);
        b_rst_n = 1'b0;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge sysclk);
            if (b_out_valid) pulses++;
        end
        b_rst_n = 1'b1;
        chk("abort_pulses", pulses, 0);
        chk("abort_data_out", int'(b_data_out), 385);
        chk("abort_busy", int'(b_busy), 0);
        $display("abort dut=1 pulses=%0d data_out=%0d", pulses, b_data_out);
        hist.delete();
        exp_q.delete();
        send(1'b1, 641, 3, 1);
        for (int i = 0; i < 7; i++) send(1'b1, 385, 3, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
